// File: rtl/memory_access.sv
// memory_access: RV32I memory stage.
// Takes the execute stage's ALU result, effective address, store data and rd.
// Non-memory instructions produce a registered writeback one cycle later.
// Loads and stores run one at a time over a req/ack data bus. The upstream
// stage is stalled while an access is outstanding.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   valid_in, opcode_in,    instruction from execute: opcode, funct3,
//   funct3_in, addr_in,     effective address, rs2 value, ALU result,
//   store_data_in,          destination register and its write flag
//   result_in, rd_in,
//   rd_write_in
//   stall_out               combinational stall to the upstream stage
//   mem_req_out, mem_we_out,  data-memory request: word address, byte
//   mem_addr_out,             enables and lane-aligned write data
//   mem_be_out, mem_wdata_out
//   mem_rdata_in, mem_ack_in  read data and completion from the memory
//   wb_valid_out, wb_write_out, wb_rd_out, wb_data_out  writeback record (pulse)
//   misaligned_out          fault pulse: misaligned address or illegal funct3
//   timeout_out             fault pulse: no ack within ACK_TIMEOUT cycles
module memory_access #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] result_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  output logic        stall_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  mem_be_out,
  output logic [31:0] mem_wdata_out,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_ack_in,
  output logic        wb_valid_out,
  output logic        wb_write_out,
  output logic [4:0]  wb_rd_out,
  output logic [31:0] wb_data_out,
  output logic        misaligned_out,
  output logic        timeout_out
);

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [16:0] TIMEOUT_LIMIT = 17'(ACK_TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_reg;
  logic [15:0] count_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;
  logic [4:0]  rd_reg;
  logic        rd_write_reg;

  // ---------------- request decode ----------------
  logic is_load, is_store, is_mem;
  logic size_legal, aligned, mem_ok, mem_bad;

  assign is_load  = (opcode_in == OP_LOAD);
  assign is_store = (opcode_in == OP_STORE);
  assign is_mem   = is_load || is_store;

  always_comb begin
    size_legal = 1'b0;
    aligned    = 1'b1;
    case (funct3_in)
      3'b000: size_legal = 1'b1;
      3'b001: begin size_legal = 1'b1; aligned = ~addr_in[0]; end
      3'b010: begin size_legal = 1'b1; aligned = (addr_in[1:0] == 2'b00); end
      3'b100, 3'b101: size_legal = is_load;  // LBU/LHU exist only as loads
      default: size_legal = 1'b0;
    endcase
    // unsigned halfword load carries the same alignment rule as LH
    if (funct3_in == 3'b101) aligned = ~addr_in[0];
  end

  assign mem_ok  = is_mem && size_legal && aligned;
  assign mem_bad = is_mem && !(size_legal && aligned);

  assign stall_out = (state_reg == WAIT) ||
                     (state_reg == IDLE && valid_in && mem_ok);

  // ---------------- store lane steering ----------------
  logic [31:0] byte_rep, half_rep;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_rep
    assign byte_rep[gi*8 +: 8] = store_data_in[7:0];
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_half_rep
    assign half_rep[gi*16 +: 16] = store_data_in[15:0];
  end

  logic [3:0]  store_be;
  logic [31:0] store_wdata;

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = store_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        store_be    = 4'b0001 << addr_in[1:0];
        store_wdata = byte_rep;
      end
      2'b01: begin
        store_be    = addr_in[1] ? 4'b1100 : 4'b0011;
        store_wdata = half_rep;
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = store_data_in;
      end
    endcase
  end

  // ---------------- load data extraction ----------------
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  always_comb begin
    case (offset_reg)
      2'd0:    load_byte = mem_rdata_in[7:0];
      2'd1:    load_byte = mem_rdata_in[15:8];
      2'd2:    load_byte = mem_rdata_in[23:16];
      default: load_byte = mem_rdata_in[31:24];
    endcase
    load_half = offset_reg[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
    case (funct3_reg)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = mem_rdata_in;
    endcase
  end

  logic count_expired;
  assign count_expired = ({1'b0, count_reg} + 17'd1) == TIMEOUT_LIMIT;

  // ---------------- state machine ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      funct3_reg     <= '0;
      offset_reg     <= '0;
      rd_reg         <= '0;
      rd_write_reg   <= 1'b0;
      mem_req_out    <= 1'b0;
      mem_we_out     <= 1'b0;
      mem_addr_out   <= '0;
      mem_be_out     <= '0;
      mem_wdata_out  <= '0;
      wb_valid_out   <= 1'b0;
      wb_write_out   <= 1'b0;
      wb_rd_out      <= '0;
      wb_data_out    <= '0;
      misaligned_out <= 1'b0;
      timeout_out    <= 1'b0;
    end else begin
      // writeback and fault outputs are single-cycle pulses
      wb_valid_out   <= 1'b0;
      wb_write_out   <= 1'b0;
      misaligned_out <= 1'b0;
      timeout_out    <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (valid_in) begin
            if (mem_ok) begin
              mem_req_out   <= 1'b1;
              mem_we_out    <= is_store;
              mem_addr_out  <= {addr_in[31:2], 2'b00};
              mem_be_out    <= is_store ? store_be : 4'b1111;
              mem_wdata_out <= is_store ? store_wdata : 32'd0;
              funct3_reg    <= funct3_in;
              offset_reg    <= addr_in[1:0];
              rd_reg        <= rd_in;
              rd_write_reg  <= rd_write_in;
              count_reg     <= '0;
              state_reg     <= WAIT;
            end else if (mem_bad) begin
              misaligned_out <= 1'b1;
              wb_valid_out   <= 1'b1;
              wb_rd_out      <= rd_in;
              wb_data_out    <= '0;
            end else begin
              wb_valid_out <= 1'b1;
              wb_write_out <= rd_write_in && (rd_in != 5'd0);
              wb_rd_out    <= rd_in;
              wb_data_out  <= result_in;
            end
          end
        end

        WAIT: begin
          // ack takes priority over an expiring counter
          if (mem_ack_in) begin
            wb_valid_out  <= 1'b1;
            wb_write_out  <= !mem_we_out && rd_write_reg && (rd_reg != 5'd0);
            wb_rd_out     <= rd_reg;
            wb_data_out   <= mem_we_out ? 32'd0 : load_data;
            mem_req_out   <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_be_out    <= '0;
            mem_wdata_out <= '0;
            state_reg     <= IDLE;
          end else if (count_expired) begin
            timeout_out   <= 1'b1;
            wb_valid_out  <= 1'b1;
            wb_rd_out     <= rd_reg;
            wb_data_out   <= '0;
            mem_req_out   <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_be_out    <= '0;
            mem_wdata_out <= '0;
            state_reg     <= IDLE;
          end else begin
            count_reg <= count_reg + 16'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [31:0] result_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic        stall_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_wdata_out;
  logic [31:0] mem_rdata_in;
  logic        mem_ack_in;
  logic        wb_valid_out;
  logic        wb_write_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;
  logic        misaligned_out;
  logic        timeout_out;

  always #5 clk = ~clk;

  memory_access #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode_in(opcode_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .result_in(result_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
    .stall_out(stall_out), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_be_out(mem_be_out),
    .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in),
    .mem_ack_in(mem_ack_in), .wb_valid_out(wb_valid_out),
    .wb_write_out(wb_write_out), .wb_rd_out(wb_rd_out),
    .wb_data_out(wb_data_out), .misaligned_out(misaligned_out),
    .timeout_out(timeout_out)
  );

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rdwe;
    int          delay;      // WAIT cycle in which ack is given
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    logic        exp_wbw;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
      input logic [31:0] sdata, input logic [31:0] result, input logic [4:0] rd,
      input logic rdwe, input int delay, input logic [31:0] rdata,
      input logic exp_req, input logic exp_we, input logic [31:0] exp_addr,
      input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic exp_mis,
      input logic exp_wbw, input logic chk_data, input logic [31:0] exp_data);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.result = result;
    v.rd = rd; v.rdwe = rdwe; v.delay = delay; v.rdata = rdata;
    v.exp_req = exp_req; v.exp_we = exp_we; v.exp_addr = exp_addr;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_mis = exp_mis;
    v.exp_wbw = exp_wbw; v.chk_data = chk_data; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; opcode_in = '0; funct3_in = '0; addr_in = '0;
    store_data_in = '0; result_in = '0; rd_in = '0; rd_write_in = 1'b0;
    mem_ack_in = 1'b0; mem_rdata_in = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          op   f3      addr          sdata         result        rd  we dly rdata         req we  exp_addr      be       wdata         mis wbw chk exp_data
    vecs[0]  = mk(ALU, 3'b000, 32'h0,        32'h0,        32'h0000_1234, 5, 1, 0, 32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'h0000_1234);
    vecs[1]  = mk(IMM, 3'b000, 32'h0,        32'h0,        32'h0000_DEAD, 0, 1, 0, 32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 1, 32'h0000_DEAD);
    vecs[2]  = mk(LD,  3'b000, 32'h0000_1003, 32'h0,       32'h0,         7, 1, 3, 32'h80FF_FF00, 1, 0, 32'h0000_1000, 4'hF, 32'h0,        0, 1, 1, 32'hFFFF_FF80);
    vecs[3]  = mk(ST,  3'b001, 32'h0000_2002, 32'hABCD_5678, 32'h0,       3, 1, 1, 32'h0,        1, 1, 32'h0000_2000, 4'hC, 32'h5678_5678, 0, 0, 0, 32'h0);
    vecs[4]  = mk(LD,  3'b010, 32'h0000_3001, 32'h0,       32'h0,         8, 1, 0, 32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        1, 0, 0, 32'h0);
    vecs[5]  = mk(ST,  3'b000, 32'h0000_4001, 32'h0000_00A5, 32'h0,       2, 1, 4, 32'h0,        1, 1, 32'h0000_4000, 4'h2, 32'hA5A5_A5A5, 0, 0, 0, 32'h0);
    vecs[6]  = mk(LD,  3'b101, 32'h0000_5002, 32'h0,       32'h0,         9, 1, 1, 32'h8765_4321, 1, 0, 32'h0000_5000, 4'hF, 32'h0,        0, 1, 1, 32'h0000_8765);
    vecs[7]  = mk(LD,  3'b001, 32'h0000_5000, 32'h0,       32'h0,        10, 1, 2, 32'h1234_F00D, 1, 0, 32'h0000_5000, 4'hF, 32'h0,        0, 1, 1, 32'hFFFF_F00D);
    vecs[8]  = mk(LD,  3'b100, 32'h0000_6002, 32'h0,       32'h0,        11, 1, 1, 32'h11C3_2233, 1, 0, 32'h0000_6000, 4'hF, 32'h0,        0, 1, 1, 32'h0000_00C3);
    vecs[9]  = mk(LD,  3'b010, 32'h0000_7004, 32'h0,       32'h0,        12, 1, 1, 32'hCAFE_BABE, 1, 0, 32'h0000_7004, 4'hF, 32'h0,        0, 1, 1, 32'hCAFE_BABE);
    vecs[10] = mk(LD,  3'b011, 32'h0000_0000, 32'h0,       32'h0,        13, 1, 0, 32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        1, 0, 0, 32'h0);
    vecs[11] = mk(ST,  3'b100, 32'h0000_0000, 32'h0,       32'h0,        14, 1, 0, 32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        1, 0, 0, 32'h0);
    vecs[12] = mk(ST,  3'b001, 32'h0000_2001, 32'h0,       32'h0,         1, 1, 0, 32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        1, 0, 0, 32'h0);
    vecs[13] = mk(LD,  3'b000, 32'h0000_0100, 32'h0,       32'h0,         0, 1, 1, 32'h0000_0077, 1, 0, 32'h0000_0100, 4'hF, 32'h0,        0, 0, 0, 32'h0);
    vecs[14] = mk(LD,  3'b010, 32'h0000_0200, 32'h0,       32'h0,         4, 0, 1, 32'h1111_2222, 1, 0, 32'h0000_0200, 4'hF, 32'h0,        0, 0, 0, 32'h0);

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_req", 32'(mem_req_out), 32'd0);
    chk("rst_we", 32'(mem_we_out), 32'd0);
    chk("rst_addr", mem_addr_out, 32'd0);
    chk("rst_be", 32'(mem_be_out), 32'd0);
    chk("rst_wdata", mem_wdata_out, 32'd0);
    chk("rst_wbv", 32'(wb_valid_out), 32'd0);
    chk("rst_wbw", 32'(wb_write_out), 32'd0);
    chk("rst_wbrd", 32'(wb_rd_out), 32'd0);
    chk("rst_wbdata", wb_data_out, 32'd0);
    chk("rst_mis", 32'(misaligned_out), 32'd0);
    chk("rst_to", 32'(timeout_out), 32'd0);
    reset = 1'b0;
    tick();
    $display("reset: outputs checked");

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 15; i++) begin
      valid_in = 1'b1; opcode_in = vecs[i].op; funct3_in = vecs[i].f3;
      addr_in = vecs[i].addr; store_data_in = vecs[i].sdata;
      result_in = vecs[i].result; rd_in = vecs[i].rd; rd_write_in = vecs[i].rdwe;
      #1;
      chk($sformatf("v%0d_stall_accept", i), 32'(stall_out), 32'(vecs[i].exp_req));
      tick();
      idle_inputs();
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d_req", i), 32'(mem_req_out), 32'd1);
        chk($sformatf("v%0d_we", i), 32'(mem_we_out), 32'(vecs[i].exp_we));
        chk($sformatf("v%0d_addr", i), mem_addr_out, vecs[i].exp_addr);
        chk($sformatf("v%0d_be", i), 32'(mem_be_out), 32'(vecs[i].exp_be));
        chk($sformatf("v%0d_wdata", i), mem_wdata_out, vecs[i].exp_wdata);
        chk($sformatf("v%0d_wbv_early", i), 32'(wb_valid_out), 32'd0);
        for (int w = 1; w <= vecs[i].delay; w++) begin
          chk($sformatf("v%0d_stall_w%0d", i, w), 32'(stall_out), 32'd1);
          if (w == vecs[i].delay) begin
            mem_ack_in = 1'b1;
            mem_rdata_in = vecs[i].rdata;
          end
          tick();
          mem_ack_in = 1'b0;
          mem_rdata_in = '0;
          if (w < vecs[i].delay) begin
            chk($sformatf("v%0d_req_held%0d", i, w), 32'(mem_req_out), 32'd1);
            chk($sformatf("v%0d_addr_held%0d", i, w), mem_addr_out, vecs[i].exp_addr);
          end
        end
        chk($sformatf("v%0d_req_drop", i), 32'(mem_req_out), 32'd0);
        chk($sformatf("v%0d_to", i), 32'(timeout_out), 32'd0);
        chk($sformatf("v%0d_wbrd", i), 32'(wb_rd_out), 32'(vecs[i].rd));
      end else begin
        chk($sformatf("v%0d_noreq", i), 32'(mem_req_out), 32'd0);
        chk($sformatf("v%0d_mis", i), 32'(misaligned_out), 32'(vecs[i].exp_mis));
        if (!vecs[i].exp_mis)
          chk($sformatf("v%0d_wbrd", i), 32'(wb_rd_out), 32'(vecs[i].rd));
      end
      chk($sformatf("v%0d_wbv", i), 32'(wb_valid_out), 32'd1);
      chk($sformatf("v%0d_wbw", i), 32'(wb_write_out), 32'(vecs[i].exp_wbw));
      if (vecs[i].chk_data)
        chk($sformatf("v%0d_wbdata", i), wb_data_out, vecs[i].exp_data);
      tick();
      chk($sformatf("v%0d_wbv_pulse", i), 32'(wb_valid_out), 32'd0);
      chk($sformatf("v%0d_mis_pulse", i), 32'(misaligned_out), 32'd0);
      chk($sformatf("v%0d_stall_idle", i), 32'(stall_out), 32'd0);
      $display("vec %0d: op=%b f3=%b addr=%h rd=%0d -> wb_data=%h", i,
               vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].rd, wb_data_out);
    end

    // ---------------- timeout: LHU with no ack ----------------
    valid_in = 1'b1; opcode_in = LD; funct3_in = 3'b101; addr_in = 32'h0000_8000;
    rd_in = 5'd6; rd_write_in = 1'b1;
    tick();
    idle_inputs();
    chk("to_req_start", 32'(mem_req_out), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c < 4) begin
        chk($sformatf("to_req_held%0d", c), 32'(mem_req_out), 32'd1);
        chk($sformatf("to_nopulse%0d", c), 32'(timeout_out), 32'd0);
      end else begin
        chk("to_req_drop", 32'(mem_req_out), 32'd0);
        chk("to_pulse", 32'(timeout_out), 32'd1);
        chk("to_wbv", 32'(wb_valid_out), 32'd1);
        chk("to_wbw", 32'(wb_write_out), 32'd0);
      end
    end
    tick();
    chk("to_pulse_end", 32'(timeout_out), 32'd0);
    chk("to_idle_stall", 32'(stall_out), 32'd0);
    $display("timeout: LHU addr=00008000 abandoned after 4 wait cycles");

    // ack while IDLE is ignored
    mem_ack_in = 1'b1; mem_rdata_in = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    chk("idle_ack_wbv", 32'(wb_valid_out), 32'd0);
    chk("idle_ack_req", 32'(mem_req_out), 32'd0);
    $display("idle ack: ignored");

    // ---------------- reset in the middle of WAIT ----------------
    valid_in = 1'b1; opcode_in = LD; funct3_in = 3'b010; addr_in = 32'h0000_9000;
    rd_in = 5'd15; rd_write_in = 1'b1;
    tick();
    idle_inputs();
    chk("rw_req", 32'(mem_req_out), 32'd1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("rw_req_async", 32'(mem_req_out), 32'd0);
    chk("rw_stall", 32'(stall_out), 32'd0);
    tick();
    reset = 1'b0;
    mem_ack_in = 1'b1; mem_rdata_in = 32'h1234_5678;
    tick();
    idle_inputs();
    chk("rw_late_ack_wbv", 32'(wb_valid_out), 32'd0);
    chk("rw_late_ack_req", 32'(mem_req_out), 32'd0);
    chk("rw_no_to", 32'(timeout_out), 32'd0);
    chk("rw_no_mis", 32'(misaligned_out), 32'd0);
    $display("reset mid-wait: request dropped, late ack ignored");

    // pipeline still works after the reset
    valid_in = 1'b1; opcode_in = ALU; result_in = 32'h0BAD_F00D; rd_in = 5'd31; rd_write_in = 1'b1;
    tick();
    idle_inputs();
    chk("post_rst_wbv", 32'(wb_valid_out), 32'd1);
    chk("post_rst_wbdata", wb_data_out, 32'h0BAD_F00D);
    $display("post-reset ALU: wb_data=%h", wb_data_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // safety net against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the RV32I pipeline, sitting directly downstream of the execute stage. Consumes the execute stage's ALU result, load/store address, store data and destination register. Performs loads and stores over a single-outstanding req/ack data-memory bus and presents one registered writeback record per instruction. Stalls upstream while an access is in flight.

## Interface
- ACK_TIMEOUT, 255: cycles spent in WAIT without `mem_ack_in` before the access is abandoned (1..65535).

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- valid_in  in  1  execute presents an instruction this cycle.
- opcode_in  in  7  instruction opcode; 0000011 = load, 0100011 = store, anything else = non-memory.
- funct3_in  in  3  load/store size and sign.
- addr_in  in  32  effective address (execute LSU output).
- store_data_in  in  32  rs2 value.
- result_in  in  32  ALU result for non-memory instructions.
- rd_in  in  5  destination register.
- rd_write_in  in  1  instruction writes rd.
- stall_out  out  1  to the upstream stall input.
- mem_req_out  out  1  bus request.
- mem_we_out  out  1  1 = store.
- mem_addr_out  out  32  word-aligned address (bits [1:0] = 0).
- mem_be_out  out  4  byte enables.
- mem_wdata_out  out  32  lane-aligned store data.
- mem_rdata_in  in  32  read word, valid with ack.
- mem_ack_in  in  1  access complete.
- wb_valid_out  out  1  writeback record valid (1-cycle pulse).
- wb_write_out  out  1  write `wb_data_out` to `wb_rd_out`.
- wb_rd_out  out  5  destination register.
- wb_data_out  out  32  writeback data.
- misaligned_out  out  1  1-cycle fault pulse: misaligned or illegal funct3.
- timeout_out  out  1  1-cycle fault pulse: ack timeout.

## Operation
- States: IDLE, WAIT.
- **IDLE, non-memory `valid_in`:**
  - Next edge: `wb_valid_out=1`, `wb_data_out=result_in`, `wb_rd_out=rd_in`, `wb_write_out = rd_write_in && rd_in!=0`.
- **IDLE, load/store `valid_in`, legal and aligned:**
  - Next edge: drive the bus registers and move to WAIT. `mem_addr_out = {addr_in[31:2],2'b00}`.
  - Latch rd, funct3, `addr[1:0]`, `rd_write_in`.
- **Legality:**
  - Loads accept funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores accept 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal.
  - Halfword with `addr[0]=1` is misaligned; word with `addr[1:0]!=0` is misaligned.
- **Illegal or misaligned:**
  - No bus request.
  - Next edge: `misaligned_out=1`, `wb_valid_out=1`, `wb_write_out=0`.
  - Stay in IDLE.
- **Store lanes:**
  - SB: `be = 0001 << addr[1:0]`, wdata = byte replicated x4.
  - SH: `be = addr[1] ? 1100 : 0011`, wdata = half replicated x2.
  - SW: `be = 1111`.
  - Loads: `be = 1111`, `we = 0`, wdata = 0.
- **WAIT:**
  - Bus outputs held stable while `mem_req_out=1`; an internal counter increments each cycle.
  - On `mem_ack_in`: drop req next edge, return to IDLE, emit writeback.
  - Load writeback: byte/half selected by latched `addr[1:0]`, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW passes through.
  - Store writeback: `wb_write_out=0`.
- **Timeout:** counter reaches ACK_TIMEOUT with no ack → drop req, pulse `timeout_out`, `wb_valid_out=1` with `wb_write_out=0`, return to IDLE.
- **Ignored inputs:**
  - `mem_ack_in` in IDLE is ignored.
  - `valid_in` in WAIT is ignored; upstream is stalled.
- `wb_write_out` is forced 0 whenever rd is 0.

## Timing
- Reset: state IDLE; counter 0; every output 0 (`stall_out`, `mem_*_out`, `wb_*_out`, fault pulses).
- Reset asserted in WAIT: `mem_req_out` falls asynchronously, no writeback, no fault.
- `stall_out` (combinational) = `(state==WAIT) || (state==IDLE && valid_in && legal aligned load/store)`.
- Non-memory latency: 1 cycle, valid_in to wb_valid.
- Memory access accepted at edge E:
  - `mem_req_out` is high from E until the edge after the ack cycle.
  - Ack sampled at edge A gives writeback at A (registered); `mem_req_out` is 0 after A.
  - Minimum load-to-writeback latency is 2 cycles, with ack in the first WAIT cycle.
- Ack and timeout in the same cycle: ack wins, no timeout pulse.
- All wb and fault outputs are single-cycle pulses.

## Test plan
- ADD: `result_in=0x1234`, rd=5 → next cycle `wb_valid=1`, `wb_write=1`, rd 5, data 0x1234, no `mem_req`.
- LB, `addr=0x1003`, ack after 3 cycles with rdata 0x80FF_FF00 → `mem_addr=0x1000`; `stall_out` high 4 cycles; wb data 0xFFFF_FF80.
- SH, `addr=0x2002`, data 0xABCD_5678 → `be=1100`, `wdata=0x5678_5678`, `we=1`; after ack, `wb_write=0`.
- LW at 0x3001 → no req; `misaligned_out` pulse; `wb_valid=1`, `wb_write=0`; `stall_out` low.
- LHU with ACK_TIMEOUT=4 and no ack → req held 4 cycles, then dropped; `timeout_out` pulse; back in IDLE.
- Reset pulse mid-WAIT, then a late ack → `mem_req` low immediately; ack ignored; no writeback.
